// File: rtl/spi_duty_pkg.sv
// ---------------------------------------------------------------------------
// spi_duty_pkg
//
// Shared definitions for the SPI duty feeder slice:
//   - default duty word width and FIFO depth
//   - number of synchroniser flops on the SPI pins
//   - status word layout (overrun in the MSB, underrun just below it,
//     FIFO level in the LSBs) and helpers that place these bits for any
//     duty word width
//   - packed struct that holds the two sticky status flags
// ---------------------------------------------------------------------------
package spi_duty_pkg;

  // Default duty word width; must agree with the PWM bits parameter.
  localparam int DUTY_BITS       = 16;

  // Default FIFO depth is 2**FIFO_DEPTH_LOG2 words.
  localparam int FIFO_DEPTH_LOG2 = 2;

  // Flops between each SPI pin and the clkin domain logic.
  localparam int SPI_SYNC_STAGES = 2;

  // Status word bit positions for the default width.
  localparam int STAT_OVERRUN    = DUTY_BITS - 1;
  localparam int STAT_UNDERRUN   = DUTY_BITS - 2;

  // The same positions for an arbitrary status word width.
  function automatic int stat_overrun_pos(input int bits);
    return bits - 1;
  endfunction

  function automatic int stat_underrun_pos(input int bits);
    return bits - 2;
  endfunction

  // Sticky error flags reported to the host at the start of each frame.
  typedef struct packed {
    logic overrun;
    logic underrun;
  } stat_flags_t;

endpackage

// File: rtl/spi_duty_fifo.sv
// ---------------------------------------------------------------------------
// spi_duty_fifo
//
// Small synchronous FIFO for duty words.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   push     in   request to store wr_data
//   pop      in   request to drop the head word
//   wr_data  in   WIDTH  word to store
//   rd_data  out  WIDTH  current head word (valid while not empty)
//   level    out  DEPTH_LOG2+1  occupancy, 0..2**DEPTH_LOG2
//   full     out  level equals the depth
//   empty    out  level equals zero
//
// A pop on an empty FIFO is ignored. A push on a full FIFO is ignored,
// unless a pop happens in the same cycle and frees a slot. Full and empty
// come from the level counter, so the pointers only need to wrap.
// ---------------------------------------------------------------------------
module spi_duty_fifo
  import spi_duty_pkg::*;
#(
  parameter int WIDTH      = DUTY_BITS,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (level_q == '0);
  assign full  = (level_q == (DEPTH_LOG2 + 1)'(DEPTH));

  // A pop that actually removes a word makes room for a push in the same
  // cycle even when the FIFO is full. When full, wr_ptr equals rd_ptr, so
  // the write lands in the slot being read; the read still sees the old
  // head because the array only updates at the clock edge.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  assign rd_data = mem[rd_ptr];
  assign level   = level_q;

  // Storage array; no reset needed since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth, and the level
  // counter tracks occupancy, holding when a push and a pop coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   level_q <= level_q - (DEPTH_LOG2 + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_duty_feeder.sv
// ---------------------------------------------------------------------------
// spi_duty_feeder
//
// Front end of the PWM generator. The samd51 streams duty words over the
// user SPI link (mode 0, MSB first); they are buffered in a small FIFO and
// one word is handed to the PWM per period, clamped to the period value.
// At the start of every SPI frame the host reads back a status word on
// spi_so: {overrun, underrun, zeros, level}.
//
// Ports:
//   clkin        in   system clock (48 MHz HFOSC)
//   reset_n      in   asynchronous active-low reset
//   spi_cs       in   SPI chip select, active low, asynchronous
//   spi_sck      in   SPI clock, mode 0, at most clkin/8, asynchronous
//   spi_si       in   SPI data in, MSB first
//   spi_so       out  SPI data out (status word), MSB first, 0 while cs high
//   period_tick  in   one-cycle pulse when the PWM count reloads
//   max          in   BITS  PWM period value used to clamp duty
//   duty         out  BITS  compare value for the PWM
//   level        out  DEPTH_LOG2+1  FIFO occupancy
//   underrun     out  sticky: tick arrived with the FIFO empty
//   overrun      out  sticky: word completed with the FIFO full and dropped
//
// Build option:
//   SPI_DUTY_UNDERRUN_ZERO_EN  when defined, an underrun tick forces duty to
//                              0 on the next cycle; otherwise duty holds.
// ---------------------------------------------------------------------------
module spi_duty_feeder
  import spi_duty_pkg::*;
#(
  parameter int BITS       = DUTY_BITS,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                clkin,
  input  logic                reset_n,
  input  logic                spi_cs,
  input  logic                spi_sck,
  input  logic                spi_si,
  output logic                spi_so,
  input  logic                period_tick,
  input  logic [BITS-1:0]     max,
  output logic [BITS-1:0]     duty,
  output logic [DEPTH_LOG2:0] level,
  output logic                underrun,
  output logic                overrun
);

  localparam int CNT_W   = $clog2(BITS + 1);
  localparam int OVR_POS = stat_overrun_pos(BITS);
  localparam int UNR_POS = stat_underrun_pos(BITS);

  // Synchronisers and their edge-detect copies
  logic [SPI_SYNC_STAGES-1:0] cs_sync;
  logic [SPI_SYNC_STAGES-1:0] sck_sync;
  logic [SPI_SYNC_STAGES-1:0] si_sync;
  logic                       cs_s;
  logic                       sck_s;
  logic                       si_s;
  logic                       cs_d;
  logic                       sck_d;
  logic                       cs_fall;
  logic                       sck_rise;
  logic                       sck_fall;

  // Receive path
  logic [BITS-1:0]            rx_shift;
  logic [CNT_W-1:0]           bit_cnt;
  logic                       word_done;

  // FIFO interface
  logic [BITS-1:0]            fifo_head;
  logic [DEPTH_LOG2:0]        fifo_level;
  logic                       fifo_full;
  logic                       fifo_empty;

  // Events in the clkin domain
  logic                       pop_evt;
  logic                       underrun_evt;
  logic                       overrun_evt;

  // Status readback
  stat_flags_t                flags_q;
  logic [BITS-1:0]            status_word;
  logic [BITS-1:0]            tx_shift;

  // Bring the three SPI pins into the clkin domain. Chip select idles high
  // and the clock idles low in mode 0, so the flops reset to those levels
  // and no false edge appears after reset. The extra cs/sck copies feed
  // the edge detectors.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      si_sync  <= '0;
      cs_d     <= 1'b1;
      sck_d    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SPI_SYNC_STAGES-2:0], spi_cs};
      sck_sync <= {sck_sync[SPI_SYNC_STAGES-2:0], spi_sck};
      si_sync  <= {si_sync[SPI_SYNC_STAGES-2:0], spi_si};
      cs_d     <= cs_s;
      sck_d    <= sck_s;
    end
  end

  assign cs_s     = cs_sync[SPI_SYNC_STAGES-1];
  assign sck_s    = sck_sync[SPI_SYNC_STAGES-1];
  assign si_s     = si_sync[SPI_SYNC_STAGES-1];
  assign cs_fall  = ~cs_s & cs_d;
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;

  // A complete word sits in rx_shift for exactly one cycle after the last
  // rising edge; that cycle is the push.
  assign word_done = (bit_cnt == CNT_W'(BITS));

  // Shift in one bit per sck rising edge while selected. Clearing the
  // counter whenever cs is high throws away a partial word if the host
  // aborts a frame. After a full word the counter restarts so several
  // words may follow each other in one frame; sck is slow enough that the
  // next rising edge can never land in the push cycle.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (word_done || cs_s) begin
      bit_cnt  <= '0;
    end else if (sck_rise) begin
      rx_shift <= {rx_shift[BITS-2:0], si_s};
      bit_cnt  <= bit_cnt + CNT_W'(1);
    end
  end

  // Buffering between the host stream and the PWM period.
  spi_duty_fifo #(
    .WIDTH      (BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clkin),
    .rst_n   (reset_n),
    .push    (word_done),
    .pop     (period_tick),
    .wr_data (rx_shift),
    .rd_data (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // There is no bypass: a tick on an empty FIFO is an underrun even if a
  // word is being stored in the same cycle. A word only counts as dropped
  // when the FIFO is full and nothing is popped alongside it.
  assign pop_evt      = period_tick & ~fifo_empty;
  assign underrun_evt = period_tick & fifo_empty;
  assign overrun_evt  = word_done & fifo_full & ~pop_evt;

  assign level = fifo_level;

  // Duty register. The clamp uses max as it is at the moment of the pop,
  // so changing max later never re-clamps a value already handed over.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      duty <= '0;
    end else if (pop_evt) begin
      duty <= (fifo_head > max) ? max : fifo_head;
    end
`ifdef SPI_DUTY_UNDERRUN_ZERO_EN
    else if (underrun_evt) begin
      duty <= '0;
    end
`endif
  end

  // Sticky flags. They are cleared when the host starts a frame, because
  // that is when their values get copied into the status word; an event
  // in that very cycle must not be lost, so it wins over the clear.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else if (cs_fall) begin
      flags_q.overrun  <= overrun_evt;
      flags_q.underrun <= underrun_evt;
    end else begin
      flags_q.overrun  <= flags_q.overrun | overrun_evt;
      flags_q.underrun <= flags_q.underrun | underrun_evt;
    end
  end

  assign overrun  = flags_q.overrun;
  assign underrun = flags_q.underrun;

  // Status word layout: overrun in the MSB, underrun below it, the FIFO
  // level right-aligned and zeros in between.
  always_comb begin
    status_word                 = '0;
    status_word[OVR_POS]        = flags_q.overrun;
    status_word[UNR_POS]        = flags_q.underrun;
    status_word[DEPTH_LOG2:0]   = fifo_level;
  end

  // Transmit shifter. Loaded at the start of each frame so the MSB is on
  // the pin before the first sampling edge, then advanced on each falling
  // edge so the host sees the next bit before its next rising edge.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift <= '0;
    end else if (cs_fall) begin
      tx_shift <= status_word;
    end else if (!cs_s && sck_fall) begin
      tx_shift <= {tx_shift[BITS-2:0], 1'b0};
    end
  end

  // The pin is held low while deselected so the shared line stays quiet.
  assign spi_so = ~cs_s & tx_shift[BITS-1];

endmodule

// File: doc/spi_duty_feeder.md
Name: spi_duty_feeder

Overview:
- Upstream stage of the PWM generator. Receives 16-bit duty words from the samd51 over the user SPI link (cfg_cs/cfg_sck/cfg_si/cfg_so) and buffers them in a small FIFO.
- Presents one word on the duty output per PWM period, so the PWM latches a fresh compare value at every reload.
- Replaces the free-running duty ramp in top with host-streamed samples.

Parameters:
- BITS, 16, duty word width; must match the PWM bits parameter.
- DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 words.

Ports:
- clkin  in  1  system clock (48 MHz HFOSC).
- reset_n  in  1  asynchronous active-low reset.
- spi_cs  in  1  SPI chip select, active low, asynchronous to clkin.
- spi_sck  in  1  SPI clock, mode 0, asynchronous to clkin; must be at most clkin/8.
- spi_si  in  1  SPI data in, MSB first.
- spi_so  out  1  SPI data out, status word, MSB first.
- period_tick  in  1  one-cycle pulse, asserted in the cycle the PWM count reloads.
- max  in  BITS  PWM period value, used to clamp duty.
- duty  out  BITS  compare value to the PWM.
- level  out  DEPTH_LOG2+1  FIFO occupancy, 0..2**DEPTH_LOG2.
- underrun  out  1  sticky flag: tick arrived with FIFO empty.
- overrun  out  1  sticky flag: word completed with FIFO full, word dropped.

Behaviour:
- Reset (reset_n low, asynchronous):
  - duty=0, level=0, underrun=0, overrun=0, spi_so=0.
  - Bit counter=0; all synchronizer flops=1 for cs, 0 for sck/si.
- Input sync: spi_cs, spi_sck, spi_si each pass through 2 flops. Edges are detected from the synced value and its delayed copy.
- Receive:
  - While synced cs is low, each synced sck rising edge shifts si into the RX register LSB and increments the bit counter.
  - When the counter reaches BITS, the cycle after that edge issues a push of the full word and clears the counter.
  - If cs rises mid-word, the partial word is discarded, the counter is cleared and nothing is pushed.
  - Multiple words per cs-low frame are allowed.
- Push on full FIFO: the word is dropped and overrun is set. Exception: a pop in the same cycle frees a slot, so the push is accepted and level is unchanged.
- Pop:
  - On period_tick with level>0: pop the head; on the next cycle duty = min(head, max), comparison unsigned. Level decrements unless a push also occurs in that cycle.
  - On period_tick with level==0: set underrun; duty holds its last value.
  - No bypass: a push and a tick in the same cycle on an empty FIFO gives underrun, and the word is stored.
- Status readback:
  - On synced cs falling edge, load the TX register with {overrun, underrun, zeros, level} (BITS wide), then clear both sticky flags.
  - If a flag-setting event occurs in that same cycle, set wins.
  - spi_so = TX MSB. TX shifts left on each synced sck falling edge while cs is low.
  - spi_so is forced to 0 while cs is high.
- Pointers wrap modulo 2**DEPTH_LOG2. Full/empty are derived from level, not from pointer compare.
- max changes take effect at the next pop only; a duty already loaded is not re-clamped.

Optional Feature:
- Macro: SPI_DUTY_UNDERRUN_ZERO_EN.
- Defined: on an underrun tick, duty is forced to 0 on the next cycle (output silenced), in addition to setting underrun.
- Undefined: duty holds its last value on underrun.

Decomposition:
- Shared package spi_duty_pkg holds:
  - DUTY_BITS=16 and FIFO_DEPTH_LOG2=2 defaults.
  - Status word bit positions: STAT_OVERRUN=BITS-1, STAT_UNDERRUN=BITS-2, level in the LSBs.
  - SPI_SYNC_STAGES=2.
- One sub-module, spi_duty_fifo: synchronous FIFO with push/pop/level, parameterised by width and depth. The SPI shifter, status logic and clamp stay in spi_duty_feeder.

Test Plan:
- Push, then tick: reset, SPI-send 0x1F40, then tick with max=15999 -> duty=0x1F40 (8000) one cycle after tick; level goes 1 -> 0; no flags set.
- Clamp: send 0xFFFF with max=15999, then tick -> duty=15999.
- Overrun: send 5 words 1..5 without any tick -> level=4, overrun=1; 4 ticks -> duty sequence 1,2,3,4; 5th tick -> underrun=1, duty stays 4 (or 0 with SPI_SYNC... macro SPI_DUTY_UNDERRUN_ZERO_EN defined).
- Aborted frame: cs low, 9 bits, cs high, then a full word 0x0100 -> only 0x0100 is pushed; level=1.
- Status readback: after overrun+underrun with level=2, the next cs frame reads 0xC002 on spi_so; the following frame reads 0x0002 (flags cleared).
- Async reset: assert reset_n low mid-word with level=3 and duty=500 -> duty=0 and level=0 immediately; after release, a fresh word is received correctly from bit 0.
